mux_scan: RTL and testbench



---
 rtl/mux_scan_if.sv | 28 ++
 rtl/mux_scan.sv | 120 ++++++++++++
 tb/tb_mux_scan.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Bundle of the mux_scan data-path signals: packed channel inputs, controls and the qualified output.
// The producer/consumer side uses master; the mux itself uses slave.
interface mux_scan_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] din;
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          f;
  logic [SEL_W-1:0]          ch;
  logic                      valid;
  logic                      wrap;
  logic                      err;

  modport master (
    output din, en, mode, sel,
    input  f, ch, valid, wrap, err
  );

  modport slave (
    input  din, en, mode, sel,
    output f, ch, valid, wrap, err
  );
endinterface

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and an auto-scan sequencer that dwells
// DWELL cycles per channel. Every output word is qualified by valid.
module mux_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4
) (
  input logic        clk,
  input logic        rst,
  mux_scan_if.slave  bus
);

  localparam int unsigned SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W = $clog2(DWELL) + 1;
  localparam int unsigned SLOTS = 2 ** SEL_W;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PtrLast = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMan,
    StScan
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  // Unpack to a full power-of-two table; unused slots read as zero so any select indexes safely.
  logic [WIDTH-1:0] word [SLOTS];

  for (genvar k = 0; k < SLOTS; k++) begin : g_word
    if (k < CHANNELS) begin : g_used
      assign word[k] = bus.din[k*WIDTH +: WIDTH];
    end else begin : g_unused
      assign word[k] = '0;
    end
  end

  logic sel_ok;
  assign sel_ok = (32'(bus.sel) < CHANNELS);

  // Priority: en first, then mode; reset is applied in the register process.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    f_d     = f_q;
    ch_d    = ch_q;
    err_d   = err_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;

    if (!bus.en) begin
      state_d = StIdle;
    end else if (!bus.mode) begin
      state_d = StMan;
      f_d     = sel_ok ? word[bus.sel] : '0;
      ch_d    = bus.sel;
      err_d   = ~sel_ok;
      valid_d = 1'b1;
    end else if (state_q != StScan) begin
      state_d = StScan;
      cnt_d   = '0;
      ptr_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (cnt_q == CntLast) begin
        cnt_d   = '0;
        f_d     = word[ptr_q];
        ch_d    = ptr_q;
        valid_d = 1'b1;
        // Explicit compare so non-power-of-two channel counts wrap correctly.
        if (ptr_q == PtrLast) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      f_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      f_q     <= f_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.f     = f_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: three configurations share one stimulus stream; a reference model
// queues the expected outputs per edge and a negedge monitor compares them.
module tb_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        mode;
  logic [2:0]  sel;
  logic [39:0] din;

  mux_scan_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
  mux_scan_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();
  mux_scan_if #(.WIDTH(8), .CHANNELS(5)) bus_c ();

  assign bus_a.din  = din[31:0];
  assign bus_a.en   = en;
  assign bus_a.mode = mode;
  assign bus_a.sel  = sel[1:0];
  assign bus_b.din  = din[23:0];
  assign bus_b.en   = en;
  assign bus_b.mode = mode;
  assign bus_b.sel  = sel[1:0];
  assign bus_c.din  = din;
  assign bus_c.en   = en;
  assign bus_c.mode = mode;
  assign bus_c.sel  = sel;

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  mux_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  typedef struct packed {
    logic [7:0] f;
    logic [2:0] ch;
    logic       valid;
    logic       wrap;
    logic       err;
  } obs_t;

  int unsigned chans  [3] = '{4, 3, 5};
  int unsigned dwells [3] = '{4, 2, 1};
  int unsigned selmask[3] = '{3, 3, 7};

  // Model state: 0 idle, 1 manual, 2 scanning; age counts edges since scan entry.
  int          m_st [3];
  int unsigned m_age[3];
  obs_t        m_out[3];

  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  function automatic logic [7:0] word_of(input logic [39:0] d, input int unsigned k);
    return d[k*8 +: 8];
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int unsigned s;
      s = int'(sel) & selmask[i];
      m_out[i].valid = 1'b0;
      m_out[i].wrap  = 1'b0;
      if (rst) begin
        m_st[i]  = 0;
        m_out[i] = '0;
      end else if (!en) begin
        m_st[i] = 0;
      end else if (!mode) begin
        m_st[i]        = 1;
        m_out[i].ch    = 3'(s);
        m_out[i].err   = (s >= chans[i]);
        m_out[i].f     = (s < chans[i]) ? word_of(din, s) : 8'h00;
        m_out[i].valid = 1'b1;
      end else if (m_st[i] != 2) begin
        m_st[i]      = 2;
        m_age[i]     = 0;
        m_out[i].err = 1'b0;
      end else begin
        m_age[i]++;
        if (m_age[i] % dwells[i] == 0) begin
          int unsigned c;
          c = (m_age[i] / dwells[i] - 1) % chans[i];
          m_out[i].f     = word_of(din, c);
          m_out[i].ch    = 3'(c);
          m_out[i].valid = 1'b1;
          m_out[i].wrap  = (c == chans[i] - 1);
        end
      end
    end
    q0.push_back(m_out[0]);
    q1.push_back(m_out[1]);
    q2.push_back(m_out[2]);
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    model_edge();
    #1;
  endtask

  function automatic obs_t observe(input int i);
    obs_t o;
    case (i)
      0:       o = '{f: bus_a.f, ch: {1'b0, bus_a.ch}, valid: bus_a.valid, wrap: bus_a.wrap,
                     err: bus_a.err};
      1:       o = '{f: bus_b.f, ch: {1'b0, bus_b.ch}, valid: bus_b.valid, wrap: bus_b.wrap,
                     err: bus_b.err};
      default: o = '{f: bus_c.f, ch: bus_c.ch, valid: bus_c.valid, wrap: bus_c.wrap,
                     err: bus_c.err};
    endcase
    return o;
  endfunction

  task automatic compare(input int i, input obs_t exp);
    obs_t got;
    got = observe(i);
    checks++;
    if (got !== exp) begin
      $display("FAIL out_dut%0d cycle %0d: got f=%h ch=%0d valid=%b wrap=%b err=%b, expected f=%h ch=%0d valid=%b wrap=%b err=%b",
               i, cycle, got.f, got.ch, got.valid, got.wrap, got.err,
               exp.f, exp.ch, exp.valid, exp.wrap, exp.err);
    end else begin
      passes++;
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) compare(0, q0.pop_front());
    if (q1.size() > 0) compare(1, q1.pop_front());
    if (q2.size() > 0) compare(2, q2.pop_front());
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_st[i]  = 0;
      m_age[i] = 0;
      m_out[i] = '0;
    end
    rst  = 1'b1;
    en   = 1'b1;
    mode = 1'b0;
    sel  = 3'd2;
    din  = 40'h55_44_33_22_11;
    repeat (2) step();

    // Manual selects, including out-of-range for the 3-channel instance.
    rst = 1'b0;
    step();
    sel = 3'd0; step();
    sel = 3'd3; step();
    sel = 3'd1; step();
    sel = 3'd6; step();

    // Scan, abort with en mid-scan, restart.
    mode = 1'b1;
    repeat (9) step();
    en = 1'b0; step();
    en = 1'b1; repeat (10) step();

    // Reset mid-scan, restart.
    rst = 1'b1; repeat (2) step();
    rst = 1'b0; repeat (21) step();

    // Drop to manual mid-dwell, then resume scanning through several wraps.
    mode = 1'b0; sel = 3'd1; step();
    mode = 1'b1; repeat (6) step();
    mode = 1'b0; sel = 3'd2; step();
    mode = 1'b1; repeat (25) step();

    // Randomised traffic; din changes every cycle so only capture edges matter.
    repeat (500) begin
      din = {8'($urandom), 32'($urandom)};
      sel = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 59) == 0);
      if (en) begin
        if ($urandom_range(0, 29) == 0) en = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      step();
    end

    en = 1'b0;
    step();
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      $display("FAIL queue_drain: got %0d pending entries, expected 0",
               q0.size() + q1.size() + q2.size());
    end else begin
      passes++;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
